// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: loop-controller state encoding and default
// widths that must agree between the DCO and its frequency controller.
package adpll_pkg;

    localparam int CTRL_WIDTH_DEF = 5;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

endpackage

// File: rtl/dco_freq_ctrl_if.sv
// Signal bundle between the frequency controller (slave side) and the
// system/DCO that drives its inputs and consumes its outputs (master side).
interface dco_freq_ctrl_if
    import adpll_pkg::*;
#(
    parameter int CTRL_WIDTH = CTRL_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
);
    logic                  enable_i;
    logic                  dco_div_i;
    logic [CNT_WIDTH-1:0]  target_count_i;
    logic [CTRL_WIDTH-1:0] freq_sel_o;
    logic                  dco_enable_o;
    logic                  locked_o;
    logic [CNT_WIDTH-1:0]  meas_count_o;
    logic                  meas_valid_o;
    logic                  sat_o;
    state_t                state_o;

    // meas_valid_o is a one-cycle pulse qualifying meas_count_o, sat_o and the
    // new freq_sel_o; there is no ready, so the consumer must take it that cycle.
    modport slave (
        input  enable_i, dco_div_i, target_count_i,
        output freq_sel_o, dco_enable_o, locked_o, meas_count_o, meas_valid_o,
        output sat_o, state_o
    );

    modport master (
        output enable_i, dco_div_i, target_count_i,
        input  freq_sel_o, dco_enable_o, locked_o, meas_count_o, meas_valid_o,
        input  sat_o, state_o
    );
endinterface

// File: rtl/dco_freq_ctrl_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a history flop that
// yields one clk_i pulse per rising edge of that input.
module sync_edge_det (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic edge_o
);
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_o = s2_q & ~s3_q;
endmodule

// File: rtl/dco_freq_ctrl.sv
// Frequency-lock loop controller: counts DCO edges per fixed clk_i window and
// steps the DCO code by one per window until the count sits within tolerance.
module dco_freq_ctrl
    import adpll_pkg::*;
#(
    parameter int CTRL_WIDTH    = CTRL_WIDTH_DEF,
    parameter int CNT_WIDTH     = CNT_WIDTH_DEF,
    parameter int WINDOW_CYCLES = 1024,
    parameter int LOCK_TOL      = 2,
    parameter int LOCK_CONSEC   = 4,
    parameter int INIT_CODE     = 16
) (
    input logic            clk_i,
    input logic            reset_i,
    dco_freq_ctrl_if.slave bus
);
    localparam int WIN_W  = $clog2(WINDOW_CYCLES);
    localparam int LOCK_W = $clog2(LOCK_CONSEC + 1);
    localparam int ERR_W  = CNT_WIDTH + 1;
    localparam logic [WIN_W-1:0]      WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [LOCK_W-1:0]     LOCK_FULL = LOCK_W'(LOCK_CONSEC);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
    localparam logic [CTRL_WIDTH-1:0] CODE_MAX  = '1;
    localparam logic signed [ERR_W-1:0] TOL_POS = $signed(ERR_W'(LOCK_TOL));
    localparam logic signed [ERR_W-1:0] TOL_NEG = -TOL_POS;

    state_t                state_q, state_d;
    logic [WIN_W-1:0]      win_q, win_d;
    logic [CNT_WIDTH-1:0]  edge_cnt_q, edge_cnt_d;
    logic [CNT_WIDTH-1:0]  cap_q, cap_d;
    logic [CNT_WIDTH-1:0]  tgt_q, tgt_d;
    logic                  pend_q, pend_d;
    logic [CTRL_WIDTH-1:0] code_q, code_d;
    logic [CNT_WIDTH-1:0]  meas_q, meas_d;
    logic                  valid_q, valid_d;
    logic                  sat_q, sat_d;
    logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic                  locked_q, locked_d;

    logic                  dco_edge;
    logic                  terminal;
    logic                  in_tol;
    logic [CNT_WIDTH-1:0]  edge_inc;
    logic signed [ERR_W-1:0] err_s;

    sync_edge_det u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (bus.dco_div_i),
        .edge_o  (dco_edge)
    );

    assign terminal = (win_q == WIN_LAST);
    assign edge_inc = (dco_edge && edge_cnt_q != CNT_MAX) ? edge_cnt_q + 1'b1 : edge_cnt_q;
    assign err_s    = $signed({1'b0, tgt_q}) - $signed({1'b0, cap_q});

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        edge_cnt_d = edge_cnt_q;
        cap_d      = cap_q;
        tgt_d      = tgt_q;
        pend_d     = pend_q;
        code_d     = code_q;
        meas_d     = meas_q;
        valid_d    = 1'b0;
        sat_d      = sat_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        in_tol     = 1'b0;

        if (state_q == ST_IDLE || !bus.enable_i) begin
            // Leaving or sitting idle: drop any in-flight capture and lock history.
            state_d    = bus.enable_i ? ST_SETTLE : ST_IDLE;
            win_d      = '0;
            edge_cnt_d = '0;
            pend_d     = 1'b0;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else begin
            win_d      = terminal ? '0 : win_q + 1'b1;
            edge_cnt_d = terminal ? '0 : edge_inc;

            if (pend_q) begin
                pend_d  = 1'b0;
                valid_d = 1'b1;
                meas_d  = cap_q;
                if (err_s > TOL_POS) begin
                    sat_d = (code_q == CODE_MAX);
                    if (code_q != CODE_MAX) code_d = code_q + 1'b1;
                end else if (err_s < TOL_NEG) begin
                    sat_d = (code_q == '0);
                    if (code_q != '0) code_d = code_q - 1'b1;
                end else begin
                    sat_d  = 1'b0;
                    in_tol = 1'b1;
                end
                if (in_tol) begin
                    lock_cnt_d = (lock_cnt_q == LOCK_FULL) ? lock_cnt_q : lock_cnt_q + 1'b1;
                end else begin
                    lock_cnt_d = '0;
                end
                locked_d = (lock_cnt_d == LOCK_FULL);
            end

            if (terminal) begin
                if (state_q == ST_SETTLE) begin
                    state_d = ST_RUN;
                end else begin
                    cap_d  = edge_inc;
                    tgt_d  = bus.target_count_i;
                    pend_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            edge_cnt_q <= '0;
            cap_q      <= '0;
            tgt_q      <= '0;
            pend_q     <= 1'b0;
            code_q     <= CTRL_WIDTH'(INIT_CODE);
            meas_q     <= '0;
            valid_q    <= 1'b0;
            sat_q      <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            edge_cnt_q <= edge_cnt_d;
            cap_q      <= cap_d;
            tgt_q      <= tgt_d;
            pend_q     <= pend_d;
            code_q     <= code_d;
            meas_q     <= meas_d;
            valid_q    <= valid_d;
            sat_q      <= sat_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign bus.freq_sel_o   = code_q;
    assign bus.dco_enable_o = (state_q != ST_IDLE);
    assign bus.locked_o     = locked_q;
    assign bus.meas_count_o = meas_q;
    assign bus.meas_valid_o = valid_q;
    assign bus.sat_o        = sat_q;
    assign bus.state_o      = state_q;
endmodule

// File: tb/tb_dco_freq_ctrl.sv
// Bench for dco_freq_ctrl: three instances (init code 16, 31, 0) share clock,
// reset, enable and DCO stimulus; expectations come from a window-level model.
module tb_dco_freq_ctrl;
    localparam int WIN  = 100;
    localparam int TOL  = 1;
    localparam int CONS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic dco = 1'b0;
    logic man = 1'b0;
    logic nxt;
    int   period = 0;
    int   phase  = 0;
    int   cyc    = 0;
    int   tgt16  = 0;
    int   tgt31  = 0;
    int   tgt0   = 0;

    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    bit   det[int];
    int   e_start;
    int   k_win;
    int   m_code, m_lock, m_meas;
    bit   m_locked, m_sat;

    dco_freq_ctrl_if #(.CTRL_WIDTH(5), .CNT_WIDTH(16)) if16 ();
    dco_freq_ctrl_if #(.CTRL_WIDTH(5), .CNT_WIDTH(16)) if31 ();
    dco_freq_ctrl_if #(.CTRL_WIDTH(5), .CNT_WIDTH(16)) if0 ();

    assign if16.enable_i = en;
    assign if31.enable_i = en;
    assign if0.enable_i  = en;
    assign if16.dco_div_i = dco;
    assign if31.dco_div_i = dco;
    assign if0.dco_div_i  = dco;
    assign if16.target_count_i = 16'(tgt16);
    assign if31.target_count_i = 16'(tgt31);
    assign if0.target_count_i  = 16'(tgt0);

    dco_freq_ctrl #(.CTRL_WIDTH(5), .CNT_WIDTH(16), .WINDOW_CYCLES(WIN), .LOCK_TOL(TOL),
                    .LOCK_CONSEC(CONS), .INIT_CODE(16))
        u16 (.clk_i(clk), .reset_i(rst), .bus(if16));
    dco_freq_ctrl #(.CTRL_WIDTH(5), .CNT_WIDTH(16), .WINDOW_CYCLES(WIN), .LOCK_TOL(TOL),
                    .LOCK_CONSEC(CONS), .INIT_CODE(31))
        u31 (.clk_i(clk), .reset_i(rst), .bus(if31));
    dco_freq_ctrl #(.CTRL_WIDTH(5), .CNT_WIDTH(16), .WINDOW_CYCLES(WIN), .LOCK_TOL(TOL),
                    .LOCK_CONSEC(CONS), .INIT_CODE(0))
        u0 (.clk_i(clk), .reset_i(rst), .bus(if0));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DCO stimulus changes on negedges; a rise driven in cycle n is seen by the
    // edge detector in cycle n+2, which is the cycle recorded for window sums.
    always @(negedge clk) begin
        if (period == 0) begin
            phase = 0;
            nxt   = man;
        end else begin
            phase = (phase + 1 >= period) ? 0 : phase + 1;
            nxt   = (phase < period / 2);
        end
        if (nxt && !dco) det[cyc + 2] = 1'b1;
        dco = nxt;
    end

    function automatic int win_edges(int w0);
        int s = 0;
        for (int i = w0; i < w0 + WIN; i++) if (det.exists(i)) s++;
        return (s > 65535) ? 65535 : s;
    endfunction

    function automatic void model_reset();
        m_code = 16; m_lock = 0; m_locked = 0; m_sat = 0; m_meas = 0;
    endfunction

    function automatic void model_disable();
        m_lock = 0; m_locked = 0;
    endfunction

    function automatic void model_update(int cnt, int tgt);
        int err = tgt - cnt;
        bit ok  = 1'b0;
        if (err > TOL) begin
            if (m_code == 31) m_sat = 1; else begin m_code++; m_sat = 0; end
        end else if (err < -TOL) begin
            if (m_code == 0) m_sat = 1; else begin m_code--; m_sat = 0; end
        end else begin
            m_sat = 0; ok = 1'b1;
        end
        if (ok) begin
            if (m_lock < CONS) m_lock++;
        end else begin
            m_lock = 0;
        end
        m_locked = (m_lock == CONS);
        m_meas   = cnt;
    endfunction

    task automatic wait_until(int c, output int pulses);
        pulses = 0;
        while (cyc < c) begin
            @(negedge clk);
            if (cyc < c && if16.meas_valid_o === 1'b1) pulses++;
        end
    endtask

    task automatic enable_loop();
        en = 1'b1;
        e_start = cyc + 1;
        k_win = 1;
    endtask

    // Advances to the cycle in which window k_win's result must be visible.
    task automatic next_update(output int pulses, output int cnt);
        int t = e_start + WIN * k_win + WIN - 1;
        wait_until(t + 2, pulses);
        cnt = win_edges(e_start + WIN * k_win);
        model_update(cnt, tgt16);
        k_win++;
    endtask

    task automatic pulse_at(int c);
        do begin @(posedge clk); #1; end while (cyc < c);
        man = 1'b1;
        repeat (3) @(posedge clk);
        #1 man = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; period = 0; man = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        int p;
        do_reset();
        n_checks++; if (if16.freq_sel_o !== 5'd16) $display("FAIL reset_freq_sel: got %0d want 16", if16.freq_sel_o); else n_pass++;
        n_checks++; if (if16.dco_enable_o !== 1'b0) $display("FAIL reset_dco_enable: got %b want 0", if16.dco_enable_o); else n_pass++;
        n_checks++; if (if16.locked_o !== 1'b0) $display("FAIL reset_locked: got %b want 0", if16.locked_o); else n_pass++;
        n_checks++; if (if16.meas_valid_o !== 1'b0) $display("FAIL reset_meas_valid: got %b want 0", if16.meas_valid_o); else n_pass++;
        n_checks++; if (if16.sat_o !== 1'b0) $display("FAIL reset_sat: got %b want 0", if16.sat_o); else n_pass++;
        n_checks++; if (if16.meas_count_o !== 16'd0) $display("FAIL reset_meas_count: got %0d want 0", if16.meas_count_o); else n_pass++;
        n_checks++; if (if31.freq_sel_o !== 5'd31) $display("FAIL reset_freq_sel_31: got %0d want 31", if31.freq_sel_o); else n_pass++;
        n_checks++; if (if0.freq_sel_o !== 5'd0) $display("FAIL reset_freq_sel_0: got %0d want 0", if0.freq_sel_o); else n_pass++;
        period = 10;
        wait_until(cyc + 500, p);
        n_checks++; if (p !== 0) $display("FAIL idle_no_valid: got %0d pulses want 0", p); else n_pass++;
        n_checks++; if (if16.dco_enable_o !== 1'b0) $display("FAIL idle_dco_enable: got %b want 0", if16.dco_enable_o); else n_pass++;
        period = 0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_slow_dco();
        int p, c;
        tgt16 = 20; tgt31 = 20; tgt0 = 2;
        period = 10;
        enable_loop();
        for (int i = 0; i < 4; i++) begin
            next_update(p, c);
            n_checks++; if (p !== 0) $display("FAIL slow_extra_valid[%0d]: got %0d pulses want 0", i, p); else n_pass++;
            n_checks++; if (if16.meas_valid_o !== 1'b1) $display("FAIL slow_valid[%0d]: got %b want 1", i, if16.meas_valid_o); else n_pass++;
            n_checks++; if (if16.meas_count_o !== 16'(c)) $display("FAIL slow_meas[%0d]: got %0d want %0d", i, if16.meas_count_o, c); else n_pass++;
            n_checks++; if (if16.meas_count_o !== 16'd10) $display("FAIL slow_meas10[%0d]: got %0d want 10", i, if16.meas_count_o); else n_pass++;
            n_checks++; if (if16.freq_sel_o !== 5'(m_code)) $display("FAIL slow_code[%0d]: got %0d want %0d", i, if16.freq_sel_o, m_code); else n_pass++;
            n_checks++; if (if16.freq_sel_o !== 5'(17 + i)) $display("FAIL slow_step[%0d]: got %0d want %0d", i, if16.freq_sel_o, 17 + i); else n_pass++;
            n_checks++; if (if16.dco_enable_o !== 1'b1) $display("FAIL slow_dco_enable[%0d]: got %b want 1", i, if16.dco_enable_o); else n_pass++;
            @(negedge clk);
            n_checks++; if (if16.meas_valid_o !== 1'b0) $display("FAIL slow_valid_width[%0d]: got %b want 0", i, if16.meas_valid_o); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int p, c;
        for (int i = 0; i < 3; i++) begin
            next_update(p, c);
            n_checks++; if (if31.freq_sel_o !== 5'd31) $display("FAIL sat_hi_code[%0d]: got %0d want 31", i, if31.freq_sel_o); else n_pass++;
            n_checks++; if (if31.sat_o !== 1'b1) $display("FAIL sat_hi_flag[%0d]: got %b want 1", i, if31.sat_o); else n_pass++;
            n_checks++; if (if31.meas_count_o !== 16'(c)) $display("FAIL sat_hi_meas[%0d]: got %0d want %0d", i, if31.meas_count_o, c); else n_pass++;
            n_checks++; if (if0.freq_sel_o !== 5'd0) $display("FAIL sat_lo_code[%0d]: got %0d want 0", i, if0.freq_sel_o); else n_pass++;
            n_checks++; if (if0.sat_o !== 1'b1) $display("FAIL sat_lo_flag[%0d]: got %b want 1", i, if0.sat_o); else n_pass++;
            n_checks++; if (if16.sat_o !== m_sat) $display("FAIL sat_mid_flag[%0d]: got %b want %b", i, if16.sat_o, m_sat); else n_pass++;
        end
    endtask

    task automatic test_lock_loss();
        int p, c;
        do_reset();
        n_checks++; if (if16.freq_sel_o !== 5'd16) $display("FAIL midwin_reset_code: got %0d want 16", if16.freq_sel_o); else n_pass++;
        tgt16 = 10;
        period = 10;
        enable_loop();
        for (int i = 0; i < 4; i++) begin
            next_update(p, c);
            n_checks++; if (if16.freq_sel_o !== 5'd16) $display("FAIL lock_hold[%0d]: got %0d want 16", i, if16.freq_sel_o); else n_pass++;
            n_checks++; if (if16.locked_o !== m_locked) $display("FAIL lock_flag[%0d]: got %b want %b", i, if16.locked_o, m_locked); else n_pass++;
            n_checks++; if (if16.meas_count_o !== 16'(c)) $display("FAIL lock_meas[%0d]: got %0d want %0d", i, if16.meas_count_o, c); else n_pass++;
        end
        period = 5;
        next_update(p, c);
        n_checks++; if (if16.locked_o !== 1'b0) $display("FAIL loss_locked: got %b want 0", if16.locked_o); else n_pass++;
        n_checks++; if (if16.freq_sel_o !== 5'd15) $display("FAIL loss_code: got %0d want 15", if16.freq_sel_o); else n_pass++;
        n_checks++; if (if16.meas_count_o !== 16'(c)) $display("FAIL loss_meas: got %0d want %0d", if16.meas_count_o, c); else n_pass++;
    endtask

    task automatic test_boundary();
        int p, c, w0;
        period = 0;
        next_update(p, c);
        n_checks++; if (if16.meas_count_o !== 16'(c)) $display("FAIL bnd_pre_meas: got %0d want %0d", if16.meas_count_o, c); else n_pass++;
        w0 = e_start + WIN * k_win;
        for (int i = 1; i <= 10; i++) pulse_at(w0 + 8 * i - 2);
        pulse_at(w0 + WIN - 3);
        next_update(p, c);
        n_checks++; if (if16.meas_count_o !== 16'd11) $display("FAIL bnd_terminal_edge: got %0d want 11", if16.meas_count_o); else n_pass++;
        n_checks++; if (if16.meas_count_o !== 16'(c)) $display("FAIL bnd_meas_model: got %0d want %0d", if16.meas_count_o, c); else n_pass++;
        n_checks++; if (if16.freq_sel_o !== 5'(m_code)) $display("FAIL bnd_code: got %0d want %0d", if16.freq_sel_o, m_code); else n_pass++;
        next_update(p, c);
        n_checks++; if (if16.meas_count_o !== 16'd0) $display("FAIL bnd_next_window: got %0d want 0", if16.meas_count_o); else n_pass++;
        n_checks++; if (p !== 0) $display("FAIL bnd_extra_valid: got %0d pulses want 0", p); else n_pass++;
    endtask

    task automatic test_enable_drop();
        int p, c, w, t;
        period = 10; tgt16 = 10;
        w = e_start + WIN * k_win;
        wait_until(w + 49, p);
        en = 1'b0;
        wait_until(w + 50, p);
        model_disable();
        n_checks++; if (if16.dco_enable_o !== 1'b0) $display("FAIL drop_dco_enable: got %b want 0", if16.dco_enable_o); else n_pass++;
        n_checks++; if (if16.locked_o !== 1'b0) $display("FAIL drop_locked: got %b want 0", if16.locked_o); else n_pass++;
        n_checks++; if (if16.freq_sel_o !== 5'(m_code)) $display("FAIL drop_code: got %0d want %0d", if16.freq_sel_o, m_code); else n_pass++;
        n_checks++; if (if16.meas_count_o !== 16'(m_meas)) $display("FAIL drop_meas_hold: got %0d want %0d", if16.meas_count_o, m_meas); else n_pass++;
        wait_until(w + 250, p);
        n_checks++; if (p !== 0) $display("FAIL drop_no_valid: got %0d pulses want 0", p); else n_pass++;
        enable_loop();
        next_update(p, c);
        n_checks++; if (p !== 0) $display("FAIL reen_settle_valid: got %0d pulses want 0", p); else n_pass++;
        n_checks++; if (if16.meas_valid_o !== 1'b1) $display("FAIL reen_valid: got %b want 1", if16.meas_valid_o); else n_pass++;
        n_checks++; if (if16.meas_count_o !== 16'(c)) $display("FAIL reen_meas: got %0d want %0d", if16.meas_count_o, c); else n_pass++;
        n_checks++; if (if16.freq_sel_o !== 5'(m_code)) $display("FAIL reen_code: got %0d want %0d", if16.freq_sel_o, m_code); else n_pass++;
        // Drop enable on the cycle after capture: the pending update must vanish.
        tgt16 = 30;
        t = e_start + WIN * k_win + WIN - 1;
        wait_until(t + 1, p);
        en = 1'b0;
        wait_until(t + 2, p);
        model_disable();
        n_checks++; if (if16.meas_valid_o !== 1'b0) $display("FAIL inflight_valid: got %b want 0", if16.meas_valid_o); else n_pass++;
        n_checks++; if (if16.freq_sel_o !== 5'(m_code)) $display("FAIL inflight_code: got %0d want %0d", if16.freq_sel_o, m_code); else n_pass++;
        wait_until(cyc + 150, p);
        n_checks++; if (p !== 0) $display("FAIL inflight_late_valid: got %0d pulses want 0", p); else n_pass++;
    endtask

    task automatic test_random();
        int p, c;
        period = 0; man = 1'b0;
        tgt16 = $urandom_range(4, 24);
        enable_loop();
        wait_until(e_start + WIN, p);
        for (int i = 0; i < 4; i++) begin
            period = 4 + 2 * $urandom_range(0, 4);
            next_update(p, c);
            n_checks++; if (if16.meas_count_o !== 16'(c)) $display("FAIL rand_meas[%0d]: got %0d want %0d", i, if16.meas_count_o, c); else n_pass++;
            n_checks++; if (if16.freq_sel_o !== 5'(m_code)) $display("FAIL rand_code[%0d]: got %0d want %0d", i, if16.freq_sel_o, m_code); else n_pass++;
            n_checks++; if (if16.locked_o !== m_locked) $display("FAIL rand_locked[%0d]: got %b want %b", i, if16.locked_o, m_locked); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_slow_dco();
        test_saturation();
        test_lock_loss();
        test_boundary();
        test_enable_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
